// File: rtl/rst_seq_pkg.sv
// Shared types and widths for the reset sequencer.
// RST_SEQ_ACK_EN adds the WAIT_ACK state.
package rst_seq_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
`ifdef RST_SEQ_ACK_EN
    ST_WAIT_ACK = 2'd1,
`endif
    ST_DONE     = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] idx_inc(
    input logic [IDX_W-1:0] idx
  );
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Hold counter: sync clear, enable, terminal match.
// Saturates rather than wrapping.
module rst_seq_cnt
  import rst_seq_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             match
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign match = (cnt_q == term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Sequenced per-domain reset release controller.
// RST_SEQ_ACK_EN adds ACK input and WAIT_ACK gating.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
`ifdef RST_SEQ_ACK_EN
  input  logic [NUM_DOMAINS-1:0] ACK,
`endif
  output logic [NUM_DOMAINS-1:0] DOM_RST_N,
  output logic [IDX_W-1:0]       CUR_DOM,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_DOMAINS - 1);

  state_e                 state_q, state_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic                   done_q, done_d;

  logic cnt_en;
  logic cnt_clr;
  logic cnt_match;
  logic restart;

  assign cnt_en  = (state_q == ST_HOLD);
  assign restart = (state_q == ST_DONE) && START;
  assign cnt_clr = !RST
                 || (cnt_en && cnt_match)
                 || restart;

  rst_seq_cnt u_cnt (
    .clk   (CLK),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (TERM),
    .match (cnt_match)
  );

`ifdef RST_SEQ_ACK_EN
  logic ack_sel;

  always_comb begin
    ack_sel = 1'b0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (cur_q == IDX_W'(i)) ack_sel = ACK[i];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    dom_d   = dom_q;
    cur_d   = cur_q;
    done_d  = done_q;
    unique case (state_q)
      ST_HOLD: begin
        if (cnt_match) begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (cur_q == IDX_W'(i)) dom_d[i] = 1'b1;
          end
          if (cur_q == LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
`ifdef RST_SEQ_ACK_EN
            state_d = ST_WAIT_ACK;
`else
            cur_d   = idx_inc(cur_q);
`endif
          end
        end
      end
`ifdef RST_SEQ_ACK_EN
      // Index advances only once the ack lands.
      ST_WAIT_ACK: begin
        if (ack_sel) begin
          state_d = ST_HOLD;
          cur_d   = idx_inc(cur_q);
        end
      end
`endif
      ST_DONE: begin
        if (START) begin
          state_d = ST_HOLD;
          dom_d   = '0;
          cur_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_HOLD;
      dom_q   <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
    end
  end

  assign DOM_RST_N = dom_q;
  assign CUR_DOM   = cur_q;
  assign DONE      = done_q;
  assign BUSY      = !done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl (H=4, H=1, H=255).
// RST_SEQ_ACK_EN also exercises ACK gating.
module tb_rst_seq_ctrl;

  localparam int N = 4;
`ifdef RST_SEQ_ACK_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  typedef struct packed {
    logic [3:0] dom;
    logic [3:0] cur;
    logic       done;
  } exp_t;

  int hold [3] = '{4, 1, 255};

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic       start [3];
  logic [3:0] dom   [3];
  logic [3:0] cur   [3];
  logic       busy  [3];
  logic       done  [3];

  int   k [3];
  int   nchk = 0;
  int   nerr = 0;
  exp_t q [$];

  always #5 clk = ~clk;

`ifdef RST_SEQ_ACK_EN
  logic [3:0] ack_one = 4'hf;
  logic [3:0] ack_d;
  logic [3:0] dom_d4;
  logic [3:0] cur_d4;
  logic       busy_d4;
  logic       done_d4;
  int         rd [4] = '{4, 24, 29, 34};
  int         ad [3] = '{20, 25, 30};
`endif

  rst_seq_ctrl #(.NUM_DOMAINS(N), .HOLD_CYCLES(4)) u_a (
    .CLK(clk), .RST(rst_n[0]), .START(start[0]),
`ifdef RST_SEQ_ACK_EN
    .ACK(ack_one),
`endif
    .DOM_RST_N(dom[0]), .CUR_DOM(cur[0]),
    .BUSY(busy[0]), .DONE(done[0])
  );

  rst_seq_ctrl #(.NUM_DOMAINS(N), .HOLD_CYCLES(1)) u_b (
    .CLK(clk), .RST(rst_n[1]), .START(start[1]),
`ifdef RST_SEQ_ACK_EN
    .ACK(ack_one),
`endif
    .DOM_RST_N(dom[1]), .CUR_DOM(cur[1]),
    .BUSY(busy[1]), .DONE(done[1])
  );

  rst_seq_ctrl #(.NUM_DOMAINS(N), .HOLD_CYCLES(255)) u_c (
    .CLK(clk), .RST(rst_n[2]), .START(start[2]),
`ifdef RST_SEQ_ACK_EN
    .ACK(ack_one),
`endif
    .DOM_RST_N(dom[2]), .CUR_DOM(cur[2]),
    .BUSY(busy[2]), .DONE(done[2])
  );

`ifdef RST_SEQ_ACK_EN
  rst_seq_ctrl #(.NUM_DOMAINS(N), .HOLD_CYCLES(4)) u_d (
    .CLK(clk), .RST(rst_n[0]), .START(1'b0),
    .ACK(ack_d),
    .DOM_RST_N(dom_d4), .CUR_DOM(cur_d4),
    .BUSY(busy_d4), .DONE(done_d4)
  );
`endif

  // Edge on which domain i is released, counted from sequence start.
  function automatic int rel(input int i, input int h);
    return (i + 1) * h + i * GAP;
  endfunction

  function automatic exp_t model(input int kk, input int h);
    exp_t e;
    int   r;
    r = 0;
    for (int i = 0; i < N; i++)
      if (kk >= rel(i, h)) r = i + 1;
    e.dom  = 4'((1 << r) - 1);
    e.done = (r == N);
    e.cur  = e.done ? 4'(N - 1) : 4'(r);
    if (GAP != 0 && r > 0 && !e.done && kk == rel(r - 1, h))
      e.cur = 4'(r - 1);
    return e;
  endfunction

  function automatic int next_k(input int d);
    if (!rst_n[d]) return 0;
    if (start[d] && k[d] >= rel(N - 1, hold[d])) return 0;
    return (k[d] < 100000) ? k[d] + 1 : k[d];
  endfunction

`ifdef RST_SEQ_ACK_EN
  function automatic exp_t model_ack(input int kk);
    exp_t e;
    int   r;
    r = 0;
    for (int i = 0; i < N; i++)
      if (kk >= rd[i]) r = i + 1;
    e.dom  = 4'((1 << r) - 1);
    e.done = (r == N);
    if (e.done)                 e.cur = 4'(N - 1);
    else if (r == 0)            e.cur = 4'd0;
    else if (kk >= ad[r - 1])   e.cur = 4'(r);
    else                        e.cur = 4'(r - 1);
    return e;
  endfunction
`endif

  task automatic step(input bit chk_d);
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      k[d] = next_k(d);
      q.push_back(model(k[d], hold[d]));
    end
`ifdef RST_SEQ_ACK_EN
    if (chk_d) q.push_back(model_ack(k[0]));
`endif
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      e = q.pop_front();
      nchk++;
      if (dom[d] !== e.dom || cur[d] !== e.cur ||
          done[d] !== e.done || busy[d] !== !e.done) begin
        nerr++;
        $display("FAIL seq dut%0d edge %0d: dom=%b cur=%0d done=%b busy=%b expected dom=%b cur=%0d done=%b busy=%b",
                 d, k[d], dom[d], cur[d], done[d], busy[d],
                 e.dom, e.cur, e.done, !e.done);
      end
    end
`ifdef RST_SEQ_ACK_EN
    if (chk_d) begin
      e = q.pop_front();
      nchk++;
      if (dom_d4 !== e.dom || cur_d4 !== e.cur ||
          done_d4 !== e.done || busy_d4 !== !e.done) begin
        nerr++;
        $display("FAIL ack edge %0d: dom=%b cur=%0d done=%b busy=%b expected dom=%b cur=%0d done=%b",
                 k[0], dom_d4, cur_d4, done_d4, busy_d4,
                 e.dom, e.cur, e.done);
      end
    end
`endif
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
    step(0);
    step(0);
    nchk++;
    if (dom[0] !== 4'b0000 || busy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL reset: dom=%b busy=%b expected dom=0000 busy=1",
               dom[0], busy[0]);
    end
  endtask

  task automatic test_sequence();
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    while (k[0] < rel(N - 1, 4) + 2) step(0);
    nchk++;
    if (dom[0] !== 4'b1111 || done[0] !== 1'b1) begin
      nerr++;
      $display("FAIL sequence_end: dom=%b done=%b expected dom=1111 done=1",
               dom[0], done[0]);
    end
  endtask

  task automatic test_mid_reset();
    rst_n[0] = 1'b0;
    step(0);
    rst_n[0] = 1'b1;
    while (k[0] < 9) step(0);
    rst_n[0] = 1'b0;
    step(0);
    nchk++;
    if (dom[0] !== 4'b0000 || cur[0] !== 4'd0 || busy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL mid_reset: dom=%b cur=%0d busy=%b expected 0000/0/1",
               dom[0], cur[0], busy[0]);
    end
    rst_n[0] = 1'b1;
    while (k[0] < rel(N - 1, 4) + 1) step(0);
  endtask

  task automatic test_start_busy();
    rst_n[0] = 1'b0;
    step(0);
    rst_n[0] = 1'b1;
    while (k[0] < 5) step(0);
    start[0] = 1'b1;
    step(0);
    start[0] = 1'b0;
    nchk++;
    if (busy[0] !== 1'b1 || dom[0] !== 4'b0001) begin
      nerr++;
      $display("FAIL start_busy: dom=%b busy=%b expected 0001/1",
               dom[0], busy[0]);
    end
    while (k[0] < rel(N - 1, 4) + 2) step(0);
  endtask

  task automatic test_start_done();
    start[0] = 1'b1;
    step(0);
    start[0] = 1'b0;
    nchk++;
    if (dom[0] !== 4'b0000 || done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL start_done: dom=%b done=%b busy=%b expected 0000/0/1",
               dom[0], done[0], busy[0]);
    end
    while (k[0] < rel(N - 1, 4) + 2) step(0);
  endtask

  task automatic test_hold_extremes();
    logic [3:0] d254;
    d254 = 4'hx;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
    step(0);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    while (k[2] < 256) begin
      step(0);
      if (k[2] == 254) d254 = dom[2];
      if (k[2] == 255) begin
        nchk++;
        if (d254 !== 4'b0000 || dom[2] !== 4'b0001) begin
          nerr++;
          $display("FAIL hold255: dom@254=%b dom@255=%b expected 0000/0001",
                   d254, dom[2]);
        end
      end
    end
  endtask

`ifdef RST_SEQ_ACK_EN
  task automatic test_ack();
    ack_d = 4'b1110;
    rst_n[0] = 1'b0;
    step(1);
    rst_n[0] = 1'b1;
    while (k[0] < 38) begin
      if (k[0] == 19) ack_d[0] = 1'b1;
      step(1);
    end
  endtask
`endif

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      start[d] = 1'b0;
      k[d]     = 0;
    end
`ifdef RST_SEQ_ACK_EN
    ack_d = 4'b0000;
`endif
    #1;
    test_reset();
    test_sequence();
    test_mid_reset();
    test_start_busy();
    test_start_done();
    test_hold_extremes();
`ifdef RST_SEQ_ACK_EN
    test_ack();
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4, number of sequenced reset domains; legal range 2..16.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, clock edges each domain is held before release; legal range 1..255.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-low reset.
REQ-005 SHALL have port START  input  1  single-cycle request to re-run the full sequence.
REQ-006 SHALL have port DOM_RST_N  output  NUM_DOMAINS  per-domain reset, active-low (0 = domain held).
REQ-007 SHALL have port CUR_DOM  output  4  index of the domain currently being held or awaited.
REQ-008 SHALL have port BUSY  output  1  high while a sequence is in progress.
REQ-009 SHALL have port DONE  output  1  high once every domain is released, until the next reset or START.

Function
REQ-010 SHALL implement states HOLD, WAIT_ACK (macro builds only) and DONE.
REQ-011 SHALL release domains strictly in index order 0..NUM_DOMAINS-1, one per release edge; released bits stay 1 until reset or restart.
REQ-012 SHALL, in HOLD, count edges with an 8-bit counter and release DOM_RST_N[CUR_DOM] on the edge where the counter equals HOLD_CYCLES-1; the counter clears on that edge and never wraps.
REQ-013 SHALL, without ACK gating, treat the first RST-high edge as edge 1 and release domain i on edge (i+1)*HOLD_CYCLES.
REQ-014 SHALL, on the edge releasing domain NUM_DOMAINS-1, enter DONE: DONE=1, BUSY=0, CUR_DOM=NUM_DOMAINS-1.
REQ-015 SHALL, when START=1 is sampled in DONE, drive all DOM_RST_N to 0, CUR_DOM to 0, counter to 0, DONE to 0 and BUSY to 1 on that edge, then re-run the REQ-013 timing with that edge as edge 0.
REQ-016 SHALL ignore START while BUSY=1; the sequence proceeds undisturbed.
REQ-017 SHALL give RST=0 priority over START and over every state on the same edge.
REQ-018 SHALL keep BUSY equal to NOT DONE at all times.

Reset
REQ-019 SHALL, on any edge with RST=0 (including mid-sequence), set state HOLD, DOM_RST_N all 0, CUR_DOM 0, counter 0, BUSY 1, DONE 0.
REQ-020 SHALL start the sequence automatically on the first edge with RST=1, with no START required.

Configuration
REQ-021 SHALL, with macro RST_SEQ_ACK_EN defined, add input ACK (NUM_DOMAINS bits); after releasing domain i (i < last) the FSM enters WAIT_ACK and stays there until ACK[i]=1 is sampled.
REQ-022 SHALL, with RST_SEQ_ACK_EN defined, enter HOLD with counter 0 on the edge sampling ACK[i]=1 (E) and release domain i+1 on edge E+HOLD_CYCLES; an already-high ACK still costs one WAIT_ACK edge.
REQ-023 SHALL, without RST_SEQ_ACK_EN, have no ACK port and no WAIT_ACK state; HOLD continues directly after each release.

Structure
REQ-024 SHALL place the state encoding, the 4-bit index width and the 8-bit counter width in shared package rst_seq_pkg.
REQ-025 SHALL implement the hold counter as sub-module rst_seq_cnt (8-bit, synchronous clear, enable, terminal-match output).

Verification
REQ-026 SHALL check NUM_DOMAINS=4, HOLD_CYCLES=4, RST low then high: DOM_RST_N 0000->0001->0011->0111->1111 on edges 4, 8, 12, 16; DONE=1 from edge 16.
REQ-027 SHALL check RST pulled low at edge 10 of REQ-026: DOM_RST_N=0000, CUR_DOM=0 and BUSY=1 on that edge, then a full restart.
REQ-028 SHALL check START pulsed at edge 6 (BUSY): ignored, release times unchanged; START in DONE: all 0 next edge, re-release at +4/+8/+12/+16.
REQ-029 SHALL check HOLD_CYCLES=1: releases on edges 1, 2, 3, 4; HOLD_CYCLES=255: domain 0 released on edge 255 with no counter wrap.
REQ-030 SHALL check, with RST_SEQ_ACK_EN, ACK[0] raised at edge 20: domain 1 released at edge 24; ACK[1] held high from reset: domain 2 released 5 edges after domain 1.
